pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_step_ram.sv | 28 ++
 rtl/pattern_sequencer.sv | 99 +++++++++
 tb/tb_pattern_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and elaboration-time helpers for the pattern sequencer.
package seq_pkg;

  localparam int SEQ_DATA_WIDTH = 2;
  localparam int SEQ_NUM_STEPS  = 8;

  // Ceiling log2 for sizing; seq_clog2(1) is 0.
  function automatic int seq_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_step_ram.sv
// Step storage: one write port, one registered read port, no reset (block-RAM friendly).
module seq_step_ram #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write-first on an address collision so a freshly recorded step is visible next cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Records pattern steps on rising edges of set and plays them back one step per timer tick.
module pattern_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_WIDTH  = SEQ_DATA_WIDTH,
  parameter int NUM_STEPS   = SEQ_NUM_STEPS,
  parameter int STEP_COUNTS = 6000000 - 1,
  localparam int ADDR_WIDTH = seq_clog2(NUM_STEPS),
  localparam int LEN_WIDTH  = seq_clog2(NUM_STEPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set,
  input  logic                  clear,
  input  logic                  run_en,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic [DATA_WIDTH-1:0] led,
  output logic [ADDR_WIDTH-1:0] step_idx,
  output logic [LEN_WIDTH-1:0]  length,
  output logic                  full
);

  localparam int TIMER_WIDTH = (STEP_COUNTS > 0) ? seq_clog2(STEP_COUNTS + 1) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(STEP_COUNTS);
  localparam logic [LEN_WIDTH-1:0]   LEN_FULL   = LEN_WIDTH'(NUM_STEPS);

  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [LEN_WIDTH-1:0]   length_q, length_d;
  logic [ADDR_WIDTH-1:0]  step_q, step_d;
  logic                   set_q;
  logic                   tick;
  logic                   rise;
  logic                   full_w;
  logic                   rec;
  logic [LEN_WIDTH-1:0]   idx_next;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  assign full_w   = (length_q == LEN_FULL);
  assign rise     = set & ~set_q;
  assign tick     = run_en & (timer_q == TIMER_LAST);
  assign rec      = rise & ~full_w & ~clear & ~rst;
  assign idx_next = LEN_WIDTH'(step_q) + LEN_WIDTH'(1);

  always_comb begin
    timer_d  = timer_q;
    length_d = length_q;
    step_d   = step_q;
    if (clear) begin
      timer_d  = '0;
      length_d = '0;
      step_d   = '0;
    end else begin
      if (run_en) begin
        timer_d = tick ? '0 : timer_q + TIMER_WIDTH'(1);
      end
      if (rec) begin
        length_d = length_q + LEN_WIDTH'(1);
      end
      // Wrap decision deliberately uses the length before any same-cycle record.
      if (tick && (length_q != '0)) begin
        step_d = (idx_next >= length_q) ? '0 : ADDR_WIDTH'(idx_next);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= '0;
      length_q <= '0;
      step_q   <= '0;
      set_q    <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      length_q <= length_d;
      step_q   <= step_d;
      set_q    <= set;
    end
  end

  seq_step_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_STEPS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (rec),
    .waddr_i (ADDR_WIDTH'(length_q)),
    .wdata_i (pattern),
    .raddr_i (step_q),
    .rdata_o (ram_rdata)
  );

  // Memory is never reset, so stale contents are hidden while nothing is recorded.
  assign led      = (length_q == '0) ? '0 : ram_rdata;
  assign step_idx = step_q;
  assign length   = length_q;
  assign full     = full_w;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a 4-cycle step and 4-entry memory.
module tb_pattern_sequencer;

  logic       clk;
  logic       rst;
  logic       set;
  logic       clear;
  logic       run_en;
  logic [1:0] pattern;
  logic [1:0] led;
  logic [1:0] step_idx;
  logic [2:0] length;
  logic       full;

  int n_assert;
  int n_fail;

  pattern_sequencer #(
    .DATA_WIDTH  (2),
    .NUM_STEPS   (4),
    .STEP_COUNTS (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set      (set),
    .clear    (clear),
    .run_en   (run_en),
    .pattern  (pattern),
    .led      (led),
    .step_idx (step_idx),
    .length   (length),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic record(input logic [1:0] p);
    pattern = p;
    set     = 1'b1;
    cyc(1);
    set     = 1'b0;
    cyc(1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set      = 1'b0;
    clear    = 1'b0;
    run_en   = 1'b0;
    pattern  = 2'b00;
    cyc(2);
    chk("reset_length", 32'(length), 32'd0);
    chk("reset_idx", 32'(step_idx), 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_full", 32'(full), 32'd0);
    rst = 1'b0;

    record(2'b01);
    record(2'b10);
    record(2'b11);
    chk("rec3_length", 32'(length), 32'd3);
    chk("rec3_idx", 32'(step_idx), 32'd0);
    chk("rec3_led", 32'(led), 32'd1);
    chk("rec3_full", 32'(full), 32'd0);

    run_en = 1'b1;
    cyc(4);
    chk("play_idx1", 32'(step_idx), 32'd1);
    chk("play_led_latency", 32'(led), 32'd1);
    cyc(1);
    chk("play_led10", 32'(led), 32'd2);
    cyc(3);
    chk("play_idx2", 32'(step_idx), 32'd2);
    cyc(1);
    chk("play_led11", 32'(led), 32'd3);
    cyc(3);
    chk("play_wrap_idx", 32'(step_idx), 32'd0);
    cyc(1);
    chk("play_wrap_led", 32'(led), 32'd1);

    cyc(1);
    run_en = 1'b0;
    cyc(10);
    chk("pause_idx", 32'(step_idx), 32'd0);
    chk("pause_led", 32'(led), 32'd1);
    run_en = 1'b1;
    cyc(1);
    chk("resume_idx_hold", 32'(step_idx), 32'd0);
    cyc(1);
    chk("resume_idx_adv", 32'(step_idx), 32'd1);
    cyc(1);
    chk("resume_led", 32'(led), 32'd2);

    run_en = 1'b0;
    record(2'b00);
    chk("fill_length", 32'(length), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    record(2'b11);
    chk("over_length", 32'(length), 32'd4);
    chk("over_full", 32'(full), 32'd1);
    chk("over_led", 32'(led), 32'd2);

    run_en = 1'b1;
    cyc(3);
    chk("full_idx2", 32'(step_idx), 32'd2);
    cyc(1);
    chk("full_led11", 32'(led), 32'd3);
    cyc(4);
    chk("full_idx3", 32'(step_idx), 32'd3);
    chk("full_led00", 32'(led), 32'd0);
    cyc(4);
    chk("full_wrap_idx", 32'(step_idx), 32'd0);
    chk("full_no_fifth", 32'(led), 32'd1);

    clear   = 1'b1;
    set     = 1'b1;
    pattern = 2'b10;
    cyc(1);
    chk("clear_length", 32'(length), 32'd0);
    chk("clear_idx", 32'(step_idx), 32'd0);
    chk("clear_led", 32'(led), 32'd0);
    chk("clear_full", 32'(full), 32'd0);
    clear = 1'b0;
    cyc(1);
    chk("clear_edge_dropped", 32'(length), 32'd0);
    set = 1'b0;
    cyc(1);

    pattern = 2'b10;
    set     = 1'b1;
    cyc(1);
    chk("hold_first_led", 32'(led), 32'd2);
    cyc(19);
    chk("hold_length", 32'(length), 32'd1);
    chk("hold_led", 32'(led), 32'd2);
    chk("hold_idx", 32'(step_idx), 32'd0);
    set = 1'b0;
    cyc(1);

    record(2'b01);
    chk("pre_rst_length", 32'(length), 32'd2);
    pattern = 2'b11;
    set     = 1'b1;
    rst     = 1'b1;
    cyc(1);
    chk("rst_length", 32'(length), 32'd0);
    chk("rst_idx", 32'(step_idx), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst = 1'b0;
    cyc(1);
    chk("rst_history_length", 32'(length), 32'd1);
    chk("rst_history_led", 32'(led), 32'd3);
    set = 1'b0;
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
